// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// Bit-serial adder that works one bit per clock, LSB first, with a single carry flip-flop.
// Operands come in through a valid/ready start handshake. The result is held in DONE until it is accepted.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    count;
    logic             accept;
    logic             bit_sum;
    logic             bit_carry;

    assign accept    = (state == IDLE) && start_valid;
    assign bit_sum   = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign bit_carry = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_ready = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid)
                    next_state = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (count == LAST)
                    next_state = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                if (done_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The sum bits enter at the MSB. After WIDTH shifts, bit 0 of the result has reached bit 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            count     <= '0;
        end else if (accept) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            carry_reg <= cin;
            count     <= '0;
        end else if (state == ADD) begin
            a_reg     <= a_reg >> 1;
            b_reg     <= b_reg >> 1;
            sum_reg   <= {bit_sum, sum_reg[WIDTH-1:1]};
            carry_reg <= bit_carry;
            count     <= count + 1'b1;
        end
    end

    assign sum_out   = sum_reg;
    assign carry_out = carry_reg;

endmodule
